// File: rtl/clock_meas_pkg.sv
// Shared definitions for the clock period meter and its related blocks.
//
// Contents:
//   meas_state_t      - measurement FSM states (IDLE, ARMED, MEASURE)
//   DEFAULT_CNT_WIDTH - default width of the period / high-time counters
//   DEFAULT_TIMEOUT   - default number of in_clk cycles without a rising
//                       edge before a timeout is declared
package clock_meas_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2
  } meas_state_t;

  localparam int DEFAULT_CNT_WIDTH = 16;
  localparam int DEFAULT_TIMEOUT   = 4096;

endpackage

// File: rtl/clock_period_meter_if.sv
// Result handshake between the clock period meter and its consumer.
//
// Signals:
//   period_out   - measured period in in_clk cycles
//   high_out     - in_clk cycles the synchronised input was high in that period
//   result_valid - period_out / high_out hold a fresh result
//   result_ready - consumer takes the result when result_valid && result_ready
//
// Modports:
//   master - the meter (drives the result, observes ready)
//   slave  - the consumer (observes the result, drives ready)
interface clock_period_meter_if
  import clock_meas_pkg::*;
#(
  parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
);

  logic [CNT_WIDTH-1:0] period_out;
  logic [CNT_WIDTH-1:0] high_out;
  logic                 result_valid;
  logic                 result_ready;

  modport master (
    output period_out,
    output high_out,
    output result_valid,
    input  result_ready
  );

  modport slave (
    input  period_out,
    input  high_out,
    input  result_valid,
    output result_ready
  );

endinterface

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser with rising-edge detection for a slow signal that
// is asynchronous to in_clk.
//
// Ports:
//   in_clk  - sampling clock
//   reset   - asynchronous, active-high reset (clears all flops)
//   meas_in - asynchronous input
//   s       - synchronised copy of meas_in (SYNC_STAGES cycles of latency)
//   rise    - high for one cycle when s goes from 0 to 1
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic in_clk,
  input  logic reset,
  input  logic meas_in,
  output logic s,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev;

  // Shift chain: meas_in enters at bit 0, the settled value leaves at the
  // top bit. prev holds the settled value from one cycle earlier.
  always_ff @(posedge in_clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], meas_in};
      prev   <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~prev;

endmodule

// File: rtl/clock_period_meter.sv
// Measures the period and high time of a slow, possibly asynchronous
// clock-like signal in units of in_clk cycles and hands each result out
// over a valid/ready interface.
//
// Ports:
//   in_clk  - system clock
//   reset   - asynchronous, active-high reset
//   enable  - 1 = measure; 0 = abort and return to IDLE
//   meas_in - signal under measurement (asynchronous)
//   res     - result handshake (period_out, high_out, result_valid out;
//             result_ready in)
//   timeout - one-cycle pulse when TIMEOUT cycles pass with no rising edge
//   overrun - sticky; a result was produced while the previous one was
//             still unconsumed (cleared by reset or by dropping enable)
module clock_period_meter
  import clock_meas_pkg::*;
#(
  parameter int CNT_WIDTH   = DEFAULT_CNT_WIDTH,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = DEFAULT_TIMEOUT
) (
  input  logic                  in_clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  meas_in,
  clock_period_meter_if.master  res,
  output logic                  timeout,
  output logic                  overrun
);

  localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT = CNT_WIDTH'(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] ONE         = CNT_WIDTH'(1);

  meas_state_t          state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] hcnt;
  logic [CNT_WIDTH-1:0] s_ext;
  logic                 s;
  logic                 rise;
  logic                 capture;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .in_clk  (in_clk),
    .reset   (reset),
    .meas_in (meas_in),
    .s       (s),
    .rise    (rise)
  );

  assign s_ext   = {{(CNT_WIDTH-1){1'b0}}, s};

  // A period completes on every rise seen while measuring; the rise that
  // first leaves ARMED only starts the count.
  assign capture = (state == MEASURE) && rise;

  // Measurement FSM plus result register. The rising edge itself is counted
  // as cycle 1 of the new period (and as a high cycle), so a signal toggling
  // every in_clk reads period 2 / high 1. A rise always wins over the
  // timeout threshold, which keeps cnt bounded by TIMEOUT.
  always_ff @(posedge in_clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= '0;
      hcnt             <= '0;
      timeout          <= 1'b0;
      overrun          <= 1'b0;
      res.period_out   <= '0;
      res.high_out     <= '0;
      res.result_valid <= 1'b0;
    end else if (!enable) begin
      state            <= IDLE;
      cnt              <= '0;
      hcnt             <= '0;
      timeout          <= 1'b0;
      overrun          <= 1'b0;
      res.result_valid <= 1'b0;
    end else begin
      timeout <= 1'b0;

      case (state)
        IDLE: begin
          cnt   <= '0;
          hcnt  <= '0;
          state <= ARMED;
        end

        ARMED: begin
          if (rise) begin
            cnt   <= ONE;
            hcnt  <= ONE;
            state <= MEASURE;
          end else if (cnt == TIMEOUT_CNT) begin
            timeout <= 1'b1;
            cnt     <= '0;
          end else begin
            cnt <= cnt + ONE;
          end
        end

        MEASURE: begin
          if (rise) begin
            cnt  <= ONE;
            hcnt <= ONE;
          end else if (cnt == TIMEOUT_CNT) begin
            timeout <= 1'b1;
            cnt     <= '0;
            hcnt    <= '0;
            state   <= ARMED;
          end else begin
            cnt  <= cnt + ONE;
            hcnt <= hcnt + s_ext;
          end
        end

        default: begin
          cnt   <= '0;
          hcnt  <= '0;
          state <= IDLE;
        end
      endcase

      // A new result may replace one that is being consumed this very cycle;
      // otherwise an unconsumed result is kept and the loss is flagged.
      if (capture) begin
        if (!res.result_valid || res.result_ready) begin
          res.period_out   <= cnt;
          res.high_out     <= hcnt;
          res.result_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (res.result_valid && res.result_ready) begin
        res.result_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed self-checking bench for clock_period_meter (TIMEOUT = 64).
// meas_in is generated as a square wave of programmable period / high time,
// updated 1 time unit after each in_clk rising edge; outputs are sampled at
// the same point.
module tb_clock_period_meter;

  localparam int CNT_WIDTH = 16;
  localparam int TIMEOUT   = 64;

  logic in_clk = 1'b0;
  logic reset;
  logic enable;
  logic meas_in;
  logic timeout;
  logic overrun;

  clock_period_meter_if #(.CNT_WIDTH(CNT_WIDTH)) bus ();

  clock_period_meter #(
    .CNT_WIDTH   (CNT_WIDTH),
    .SYNC_STAGES (2),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .in_clk  (in_clk),
    .reset   (reset),
    .enable  (enable),
    .meas_in (meas_in),
    .res     (bus.master),
    .timeout (timeout),
    .overrun (overrun)
  );

  always #5 in_clk = ~in_clk;

  int assert_count = 0;
  int fail_count   = 0;

  int wave_period  = 10;
  int wave_high    = 5;
  int phase        = 0;
  bit wave_on      = 1'b0;

  bit check_results = 1'b0;
  bit check_quiet   = 1'b0;
  int exp_period    = 0;
  int exp_high      = 0;
  int accept_count  = 0;

  // One comparison: counts it, and on mismatch counts the failure and reports.
  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    assert_count++;
    assert (observed === expected)
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Advance one in_clk cycle, sample outputs, then update the waveform.
  task automatic tick();
    @(posedge in_clk);
    #1;
    if (check_results && bus.result_valid && bus.result_ready) begin
      check_output("stream period_out", bus.period_out, exp_period);
      check_output("stream high_out", bus.high_out, exp_high);
      accept_count++;
    end
    if (check_quiet) begin
      check_output("stream timeout", timeout, 1'b0);
      check_output("stream overrun", overrun, 1'b0);
    end
    if (wave_on) begin
      phase   = (phase + 1) % wave_period;
      meas_in = (phase < wave_high);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // The first tick after this call drives meas_in high (start of a period).
  task automatic start_wave(input int p, input int h);
    wave_period = p;
    wave_high   = h;
    phase       = p - 1;
    wave_on     = 1'b1;
  endtask

  task automatic stop_wave();
    wave_on = 1'b0;
    meas_in = 1'b0;
  endtask

  // Ticks until result_valid is seen; n = tick index, or -1 after 100 ticks.
  task automatic wait_valid(output int n);
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (bus.result_valid) begin
        n = i;
        break;
      end
    end
  endtask

  int n;
  int first_to;
  int to_pulses;

  initial begin
    reset            = 1'b1;
    enable           = 1'b0;
    meas_in          = 1'b0;
    bus.result_ready = 1'b1;

    // Reset state
    run(3);
    check_output("reset period_out", bus.period_out, 0);
    check_output("reset high_out", bus.high_out, 0);
    check_output("reset result_valid", bus.result_valid, 1'b0);
    check_output("reset timeout", timeout, 1'b0);
    check_output("reset overrun", overrun, 1'b0);

    // Divide-by-2 input: a result every two cycles, 2 / 1
    reset  = 1'b0;
    enable = 1'b1;
    start_wave(2, 1);
    check_quiet = 1'b1;
    run(10);
    exp_period    = 2;
    exp_high      = 1;
    accept_count  = 0;
    check_results = 1'b1;
    run(40);
    check_results = 1'b0;
    check_output("div2 accept count", accept_count, 20);

    // 50% square wave, period 10: 10 / 5
    start_wave(10, 5);
    run(40);
    exp_period    = 10;
    exp_high      = 5;
    accept_count  = 0;
    check_results = 1'b1;
    run(100);
    check_results = 1'b0;
    check_output("p10 accept count", accept_count, 10);

    // Period 8, high 2: 8 / 2
    start_wave(8, 2);
    run(40);
    exp_period    = 8;
    exp_high      = 2;
    accept_count  = 0;
    check_results = 1'b1;
    run(80);
    check_results = 1'b0;
    check_quiet   = 1'b0;
    check_output("p8 accept count", accept_count, 10);

    // Backpressure: first result held, later ones flagged as overrun
    enable = 1'b0;
    stop_wave();
    run(2);
    bus.result_ready = 1'b0;
    enable           = 1'b1;
    start_wave(10, 5);
    wait_valid(n);
    check_output("bp first valid tick", n, 14);
    check_output("bp first period", bus.period_out, 10);
    check_output("bp first high", bus.high_out, 5);
    check_output("bp overrun before", overrun, 1'b0);
    run(25);
    check_output("bp held valid", bus.result_valid, 1'b1);
    check_output("bp held period", bus.period_out, 10);
    check_output("bp overrun set", overrun, 1'b1);
    bus.result_ready = 1'b1;
    tick();
    check_output("bp valid dropped", bus.result_valid, 1'b0);
    check_output("bp overrun sticky", overrun, 1'b1);
    wait_valid(n);
    check_output("bp next valid tick", n, 4);
    check_output("bp next period", bus.period_out, 10);
    check_output("bp next high", bus.high_out, 5);

    // Timeout: one rise, then meas_in stuck low
    enable = 1'b0;
    stop_wave();
    run(3);
    enable = 1'b1;
    run(3);
    meas_in   = 1'b1;
    first_to  = -1;
    to_pulses = 0;
    for (int i = 1; i <= 80; i++) begin
      tick();
      if (i == 3) meas_in = 1'b0;
      if (timeout) begin
        to_pulses++;
        if (first_to < 0) first_to = i;
      end
    end
    check_output("to first pulse tick", first_to, 67);
    check_output("to pulse count", to_pulses, 1);
    check_output("to result_valid", bus.result_valid, 1'b0);
    // Back in ARMED: the first rise only arms, the second one captures
    start_wave(12, 4);
    wait_valid(n);
    check_output("to rearm valid tick", n, 16);
    check_output("to rearm period", bus.period_out, 12);
    check_output("to rearm high", bus.high_out, 4);

    // Reset in the middle of a period
    start_wave(10, 5);
    run(23);
    reset = 1'b1;
    #1;
    check_output("mid reset period_out", bus.period_out, 0);
    check_output("mid reset high_out", bus.high_out, 0);
    check_output("mid reset result_valid", bus.result_valid, 1'b0);
    check_output("mid reset timeout", timeout, 1'b0);
    check_output("mid reset overrun", overrun, 1'b0);
    stop_wave();
    run(3);
    reset = 1'b0;
    run(4);
    start_wave(10, 5);
    wait_valid(n);
    check_output("post reset valid tick", n, 14);
    check_output("post reset period", bus.period_out, 10);
    check_output("post reset high", bus.high_out, 5);

    // Enable dropped in the middle of a period with a pending result
    enable = 1'b0;
    stop_wave();
    run(2);
    bus.result_ready = 1'b0;
    enable           = 1'b1;
    start_wave(10, 5);
    run(40);
    check_output("dis pre valid", bus.result_valid, 1'b1);
    check_output("dis pre overrun", overrun, 1'b1);
    enable = 1'b0;
    tick();
    check_output("dis result_valid", bus.result_valid, 1'b0);
    check_output("dis overrun", overrun, 1'b0);
    check_output("dis timeout", timeout, 1'b0);
    to_pulses = 0;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (timeout) to_pulses++;
    end
    check_output("dis no timeout", to_pulses, 0);
    stop_wave();
    bus.result_ready = 1'b1;
    run(4);
    enable = 1'b1;
    start_wave(10, 5);
    wait_valid(n);
    check_output("re-enable valid tick", n, 14);
    check_output("re-enable period", bus.period_out, 10);
    check_output("re-enable high", bus.high_out, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
